// File: rtl/sum_display_pkg.sv
// Shared definitions for the sum display driver: scan states, digit count and
// the active-low seven-segment table ({g,f,e,d,c,b,a}).
package sum_display_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } scan_state_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Glyphs 0-9 and A, b, C, d, E, F; a zero bit lights the segment.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000,
        7'b1111001,
        7'b0100100,
        7'b0110000,
        7'b0011001,
        7'b0010010,
        7'b0000010,
        7'b1111000,
        7'b0000000,
        7'b0010000,
        7'b0001000,
        7'b0000011,
        7'b1000110,
        7'b0100001,
        7'b0000110,
        7'b0001110
    };

endpackage

// File: rtl/sum_display_driver_seg7_decoder.sv
// Combinational seven-segment decoder: 4-bit value plus blank flag to
// active-low segments {g,f,e,d,c,b,a}.
module seg7_decoder
    import sum_display_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : SEG_TABLE[value];

endmodule

// File: rtl/sum_display_driver.sv
// Multiplexed 4-digit display driver for a 5-bit adder result. Define
// SUM_DISPLAY_DECIMAL_EN for a decimal tens/units readout; default is hex.
module sum_display_driver
    import sum_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            sum,
    input  logic                  load,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  ovf
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [4:0]            held;
    logic [CNT_W-1:0]      refresh_cnt;
    logic                  tick;
    scan_state_t           state;
    logic [3:0]            digit_hi;
    logic [3:0]            digit_lo;
    logic [3:0]            dec_value;
    logic                  dec_blank;
    logic [6:0]            dec_seg;
    logic [NUM_DIGITS-1:0] an_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held <= 5'd0;
        end else if (load) begin
            held <= sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
        end else if (tick) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    assign tick = (refresh_cnt == CNT_LAST);

`ifdef SUM_DISPLAY_DECIMAL_EN
    // Held never exceeds 31, so a three-step compare replaces a divider.
    always_comb begin
        digit_hi = 4'd0;
        digit_lo = held[3:0];
        if (held >= 5'd30) begin
            digit_hi = 4'd3;
            digit_lo = 4'(held - 5'd30);
        end else if (held >= 5'd20) begin
            digit_hi = 4'd2;
            digit_lo = 4'(held - 5'd20);
        end else if (held >= 5'd10) begin
            digit_hi = 4'd1;
            digit_lo = 4'(held - 5'd10);
        end
    end
`else
    assign digit_hi = {3'b000, held[4]};
    assign digit_lo = held[3:0];
`endif

    always_comb begin
        dec_value = digit_lo;
        dec_blank = 1'b1;
        an_next   = '1;
        case (state)
            DIG0: begin
                dec_value = digit_lo;
                dec_blank = 1'b0;
                an_next   = 4'b1110;
            end
            DIG1: begin
                dec_value = digit_hi;
                dec_blank = (digit_hi == 4'd0);
                an_next   = 4'b1101;
            end
            DIG2: an_next = 4'b1011;
            DIG3: an_next = 4'b0111;
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .value (dec_value),
        .blank (dec_blank),
        .seg   (dec_seg)
    );

    // Scan FSM with registered pins: the pins trail the scan state by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DIG0;
            an    <= '1;
            seg   <= SEG_BLANK;
            ovf   <= 1'b0;
        end else begin
            an  <= an_next;
            seg <= dec_seg;
            ovf <= held[4];
            if (tick) begin
                case (state)
                    DIG0: state <= DIG1;
                    DIG1: state <= DIG2;
                    DIG2: state <= DIG3;
                    DIG3: state <= DIG0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sum_display_driver.sv
// Scoreboard bench for sum_display_driver with REFRESH_DIV=4; build with or
// without SUM_DISPLAY_DECIMAL_EN to match the DUT.
module tb_sum_display_driver;

    localparam int DIV = 4;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_0     = 7'b1000000;
    localparam logic [6:0] S_1     = 7'b1111001;
    localparam logic [6:0] S_3     = 7'b0110000;
    localparam logic [6:0] S_6     = 7'b0000010;
    localparam logic [6:0] S_7     = 7'b1111000;
    localparam logic [6:0] S_E     = 7'b0000110;
    localparam logic [6:0] S_F     = 7'b0001110;

`ifdef SUM_DISPLAY_DECIMAL_EN
    localparam logic [6:0] S30_LO = S_0;
    localparam logic [6:0] S30_HI = S_3;
    localparam logic [6:0] S16_LO = S_6;
    localparam logic [6:0] S31_LO = S_1;
    localparam logic [6:0] S31_HI = S_3;
`else
    localparam logic [6:0] S30_LO = S_E;
    localparam logic [6:0] S30_HI = S_1;
    localparam logic [6:0] S16_LO = S_0;
    localparam logic [6:0] S31_LO = S_F;
    localparam logic [6:0] S31_HI = S_1;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] sum   = 5'd0;
    logic       load  = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    logic [11:0] exp_q[$];
    string       name_q[$];
    logic [11:0] exp_word;
    string       exp_name;

    // Clock and reset
    always #5 clk = ~clk;

    sum_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .sum   (sum),
        .load  (load),
        .an    (an),
        .seg   (seg),
        .ovf   (ovf)
    );

    // Driver tasks
    task automatic push_exp(input logic [3:0] e_an, input logic [6:0] e_seg,
                            input logic e_ovf, input string nm);
        exp_q.push_back({e_an, e_seg, e_ovf});
        name_q.push_back(nm);
    endtask

    task automatic expect_cycles(input int n, input logic [3:0] e_an, input logic [6:0] e_seg,
                                 input logic e_ovf, input string nm);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            push_exp(e_an, e_seg, e_ovf, nm);
        end
    endtask

    // Scoreboard monitor: one expected entry per falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_word = exp_q.pop_front();
            exp_name = name_q.pop_front();
            total++;
            if ({an, seg, ovf} !== exp_word) begin
                bad++;
                $display("FAIL %s: got an=%b seg=%b ovf=%b, want an=%b seg=%b ovf=%b",
                         exp_name, an, seg, ovf, exp_word[11:8], exp_word[7:1], exp_word[0]);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        expect_cycles(3, 4'b1111, S_BLANK, 1'b0, "reset_state");
        reset = 1'b0;

        expect_cycles(4, 4'b1110, S_0,     1'b0, "init_dig0_zero");
        expect_cycles(4, 4'b1101, S_BLANK, 1'b0, "init_dig1_blank");
        expect_cycles(4, 4'b1011, S_BLANK, 1'b0, "init_dig2");
        expect_cycles(4, 4'b0111, S_BLANK, 1'b0, "init_dig3");

        sum  = 5'd30;
        load = 1'b1;
        expect_cycles(1, 4'b1110, S_0, 1'b0, "load30_latency");
        load = 1'b0;
        expect_cycles(3, 4'b1110, S30_LO,  1'b1, "s30_dig0");
        expect_cycles(4, 4'b1101, S30_HI,  1'b1, "s30_dig1");
        expect_cycles(4, 4'b1011, S_BLANK, 1'b1, "s30_dig2");
        expect_cycles(4, 4'b0111, S_BLANK, 1'b1, "s30_dig3");

        sum  = 5'd7;
        load = 1'b1;
        expect_cycles(1, 4'b1110, S30_LO, 1'b1, "load7_latency");
        load = 1'b0;
        expect_cycles(3, 4'b1110, S_7,     1'b0, "s7_dig0");
        expect_cycles(4, 4'b1101, S_BLANK, 1'b0, "s7_dig1_blank");
        expect_cycles(4, 4'b1011, S_BLANK, 1'b0, "s7_dig2");
        expect_cycles(4, 4'b0111, S_BLANK, 1'b0, "s7_dig3");

        // Load sampled on the same edge the scan leaves DIG0
        expect_cycles(3, 4'b1110, S_7, 1'b0, "pre_tick_dig0");
        sum  = 5'd16;
        load = 1'b1;
        expect_cycles(1, 4'b1110, S_7, 1'b0, "tick_load_dig0");
        load = 1'b0;
        expect_cycles(4, 4'b1101, S_1,     1'b1, "tick_load_dig1");
        expect_cycles(4, 4'b1011, S_BLANK, 1'b1, "tick_load_dig2");
        expect_cycles(4, 4'b0111, S_BLANK, 1'b1, "tick_load_dig3");

        // sum wanders with load low; display must not follow
        sum = 5'd5;
        expect_cycles(4, 4'b1110, S16_LO,  1'b1, "hold_dig0");
        sum = 5'd31;
        expect_cycles(4, 4'b1101, S_1,     1'b1, "hold_dig1");
        sum = 5'd0;
        expect_cycles(4, 4'b1011, S_BLANK, 1'b1, "hold_dig2");
        sum = 5'd12;
        expect_cycles(4, 4'b0111, S_BLANK, 1'b1, "hold_dig3");

        sum  = 5'd31;
        load = 1'b1;
        expect_cycles(1, 4'b1110, S16_LO, 1'b1, "load31_latency");
        load = 1'b0;
        expect_cycles(3, 4'b1110, S31_LO,  1'b1, "s31_dig0");
        expect_cycles(4, 4'b1101, S31_HI,  1'b1, "s31_dig1");
        expect_cycles(1, 4'b1011, S_BLANK, 1'b1, "s31_dig2");

        // Asynchronous reset in the middle of the DIG2 slot
        @(posedge clk);
        #2;
        reset = 1'b1;
        push_exp(4'b1111, S_BLANK, 1'b0, "async_reset_immediate");
        expect_cycles(2, 4'b1111, S_BLANK, 1'b0, "reset_hold");
        reset = 1'b0;
        expect_cycles(4, 4'b1110, S_0,     1'b0, "post_reset_dig0_full");
        expect_cycles(1, 4'b1101, S_BLANK, 1'b0, "post_reset_dig1");

        // Drain the scoreboard
        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
